// File: rtl/demux_1to2_pkg.sv
// Shared constants for the 1-to-2 demultiplexer: select encodings and the
// legal data width range.
package demux_pkg;

  localparam logic SEL_Y0    = 1'b0;
  localparam logic SEL_Y1    = 1'b1;
  localparam int   WIDTH_MAX = 64;

  function automatic bit width_ok(input int width);
    return (width >= 1) && (width <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/demux_1to2_if.sv
// Producer-to-demux bundle: one input word with valid and select, two steered
// output channels. There is no ready; every valid word lands on exactly one channel.
interface demux_1to2_if #(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic             sel;
  logic [WIDTH-1:0] y0;
  logic             y0_valid;
  logic [WIDTH-1:0] y1;
  logic             y1_valid;

  modport master (
    output d, d_valid, sel,
    input  y0, y0_valid, y1, y1_valid
  );

  modport slave (
    input  d, d_valid, sel,
    output y0, y0_valid, y1, y1_valid
  );

endinterface

// File: rtl/demux_1to2_out_reg.sv
// One output channel register (data plus valid packed together), cleared to
// zero by a synchronous active-high reset.
module demux_1to2_out_reg #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/demux_1to2.sv
// 1-to-2 demultiplexer: steers {d_valid, d} to channel 0 or 1 by sel, zeroing
// the other channel, with an optional one-cycle registered output stage.
module demux_1to2
  import demux_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input logic         clk,
  input logic         rst,
  demux_1to2_if.slave bus
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("demux_1to2: WIDTH=%0d outside legal range 1..%0d", WIDTH, WIDTH_MAX);
  end

  // Each channel word is {valid, data}; the unselected one is forced to zero.
  logic [WIDTH:0] w_ch0;
  logic [WIDTH:0] w_ch1;
  logic [WIDTH:0] w_out0;
  logic [WIDTH:0] w_out1;

  always_comb begin
    w_ch0 = '0;
    w_ch1 = '0;
    if (bus.sel == SEL_Y1) begin
      w_ch1 = {bus.d_valid, bus.d};
    end else begin
      w_ch0 = {bus.d_valid, bus.d};
    end
  end

  if (REG_OUT) begin : g_reg
    demux_1to2_out_reg #(.W(WIDTH + 1)) u_ch0 (
      .clk (clk),
      .rst (rst),
      .i_d (w_ch0),
      .o_q (w_out0)
    );

    demux_1to2_out_reg #(.W(WIDTH + 1)) u_ch1 (
      .clk (clk),
      .rst (rst),
      .i_d (w_ch1),
      .o_q (w_out1)
    );
  end else begin : g_comb
    // Clock and reset play no part in the combinational build.
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst;
    assign w_out0 = w_ch0;
    assign w_out1 = w_ch1;
  end

  assign bus.y0       = w_out0[WIDTH-1:0];
  assign bus.y0_valid = w_out0[WIDTH];
  assign bus.y1       = w_out1[WIDTH-1:0];
  assign bus.y1_valid = w_out1[WIDTH];

endmodule

// File: tb/tb_demux_1to2.sv
// Self-checking bench for demux_1to2 across four builds: WIDTH 1/8/16
// registered and WIDTH 4 combinational.
module tb_demux_1to2;

  typedef struct {
    logic [63:0] y0;
    logic        v0;
    logic [63:0] y1;
    logic        v1;
  } exp_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  demux_1to2_if #(.WIDTH(1))  if1  ();
  demux_1to2_if #(.WIDTH(8))  if8  ();
  demux_1to2_if #(.WIDTH(4))  if4  ();
  demux_1to2_if #(.WIDTH(16)) if16 ();

  demux_1to2 #(.WIDTH(1),  .REG_OUT(1'b1)) u_w1  (.clk(clk), .rst(rst), .bus(if1));
  demux_1to2 #(.WIDTH(8),  .REG_OUT(1'b1)) u_w8  (.clk(clk), .rst(rst), .bus(if8));
  demux_1to2 #(.WIDTH(4),  .REG_OUT(1'b0)) u_w4  (.clk(clk), .rst(rst), .bus(if4));
  demux_1to2 #(.WIDTH(16), .REG_OUT(1'b1)) u_w16 (.clk(clk), .rst(rst), .bus(if16));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sel must never be unknown once the bench is driving
  always @(negedge clk) begin
    assert (!$isunknown({if1.sel, if8.sel, if4.sel, if16.sel}))
      else $error("sel is X/Z");
  end

  // reference model: the selected channel carries the word, the other is zero
  function automatic exp_t route(input logic [63:0] d, input logic v, input logic s);
    exp_t e;
    e.y0 = s ? 64'd0 : d;
    e.v0 = v & !s;
    e.y1 = s ? d : 64'd0;
    e.v1 = v & s;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic chk_out(input string tag, input logic [63:0] y0, input logic v0,
                         input logic [63:0] y1, input logic v1, input exp_t e);
    chk({tag, "_y0"}, y0, e.y0);
    chk({tag, "_v0"}, {63'd0, v0}, {63'd0, e.v0});
    chk({tag, "_y1"}, y1, e.y1);
    chk({tag, "_v1"}, {63'd0, v1}, {63'd0, e.v1});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drivers
  task automatic drive1(input logic d, input logic v, input logic s);
    if1.d = d; if1.d_valid = v; if1.sel = s;
  endtask

  task automatic drive8(input logic [7:0] d, input logic v, input logic s);
    if8.d = d; if8.d_valid = v; if8.sel = s;
  endtask

  // scoreboard queues for the throughput run
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];

  initial begin
    exp_t        e;
    exp_t        e_prev;
    logic [63:0] w;
    logic        s;
    logic        v;
    int          seen;
    logic [1:0]  tt_d [4];
    logic [1:0]  tt_s [4];

    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    drive1(1'b0, 1'b0, 1'b0);
    drive8(8'h00, 1'b0, 1'b0);
    if4.d = 4'h0; if4.d_valid = 1'b0; if4.sel = 1'b0;
    if16.d = 16'h0; if16.d_valid = 1'b0; if16.sel = 1'b0;

    // reset state: inputs active while rst held for two edges
    drive1(1'b1, 1'b1, 1'b1);
    drive8(8'hFF, 1'b1, 1'b1);
    if16.d = 16'hBEEF; if16.d_valid = 1'b1; if16.sel = 1'b0;
    step();
    step();
    e = route(64'd0, 1'b0, 1'b0);
    chk_out("rst_w1", {63'd0, if1.y0}, if1.y0_valid, {63'd0, if1.y1}, if1.y1_valid, e);
    chk_out("rst_w8", {56'd0, if8.y0}, if8.y0_valid, {56'd0, if8.y1}, if8.y1_valid, e);
    chk_out("rst_w16", {48'd0, if16.y0}, if16.y0_valid, {48'd0, if16.y1}, if16.y1_valid, e);

    // first edge after reset release captures the held inputs
    rst = 1'b0;
    step();
    e = route(64'd1, 1'b1, 1'b1);
    chk_out("rst_rel_w1", {63'd0, if1.y0}, if1.y0_valid, {63'd0, if1.y1}, if1.y1_valid, e);

    // truth table (WIDTH=1) with a one-edge latency check
    tt_d[0] = 2'd0; tt_s[0] = 2'd0;
    tt_d[1] = 2'd1; tt_s[1] = 2'd0;
    tt_d[2] = 2'd1; tt_s[2] = 2'd1;
    tt_d[3] = 2'd0; tt_s[3] = 2'd1;
    e_prev = e;
    for (int i = 0; i < 4; i++) begin
      drive1(tt_d[i][0], 1'b1, tt_s[i][0]);
      #1;
      chk_out($sformatf("tt%0d_hold", i), {63'd0, if1.y0}, if1.y0_valid,
              {63'd0, if1.y1}, if1.y1_valid, e_prev);
      step();
      e = route({63'd0, tt_d[i][0]}, 1'b1, tt_s[i][0]);
      chk_out($sformatf("tt%0d", i), {63'd0, if1.y0}, if1.y0_valid,
              {63'd0, if1.y1}, if1.y1_valid, e);
      e_prev = e;
    end

    // mid-stream reset (WIDTH=8): 0x33 must never appear
    drive8(8'h11, 1'b1, 1'b0);
    step();
    chk_out("ms_11", {56'd0, if8.y0}, if8.y0_valid, {56'd0, if8.y1}, if8.y1_valid,
            route(64'h11, 1'b1, 1'b0));
    drive8(8'h22, 1'b1, 1'b1);
    step();
    chk_out("ms_22", {56'd0, if8.y0}, if8.y0_valid, {56'd0, if8.y1}, if8.y1_valid,
            route(64'h22, 1'b1, 1'b1));
    drive8(8'h33, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    chk_out("ms_rst", {56'd0, if8.y0}, if8.y0_valid, {56'd0, if8.y1}, if8.y1_valid,
            route(64'd0, 1'b0, 1'b0));
    rst = 1'b0;
    drive8(8'h00, 1'b0, 1'b0);
    step();
    chk_out("ms_after", {56'd0, if8.y0}, if8.y0_valid, {56'd0, if8.y1}, if8.y1_valid,
            route(64'd0, 1'b0, 1'b0));

    // valid routing: data follows sel even when not valid
    drive8(8'hA5, 1'b0, 1'b0);
    step();
    chk_out("vr_inv", {56'd0, if8.y0}, if8.y0_valid, {56'd0, if8.y1}, if8.y1_valid,
            route(64'hA5, 1'b0, 1'b0));
    drive8(8'hA5, 1'b1, 1'b1);
    step();
    chk_out("vr_val", {56'd0, if8.y0}, if8.y0_valid, {56'd0, if8.y1}, if8.y1_valid,
            route(64'hA5, 1'b1, 1'b1));

    // random registered run on WIDTH=8 with random valid
    e_prev = route(64'hA5, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      w = 64'($urandom_range(0, 255));
      v = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      drive8(w[7:0], v, s);
      step();
      chk_out($sformatf("rnd8_%0d", i), {56'd0, if8.y0}, if8.y0_valid,
              {56'd0, if8.y1}, if8.y1_valid, route(w, v, s));
    end

    // combinational build (WIDTH=4)
    if4.d = 4'hC; if4.d_valid = 1'b1; if4.sel = 1'b0;
    #1;
    chk_out("cb_s0", {60'd0, if4.y0}, if4.y0_valid, {60'd0, if4.y1}, if4.y1_valid,
            route(64'hC, 1'b1, 1'b0));
    if4.sel = 1'b1;
    #1;
    chk_out("cb_s1", {60'd0, if4.y0}, if4.y0_valid, {60'd0, if4.y1}, if4.y1_valid,
            route(64'hC, 1'b1, 1'b1));
    rst = 1'b1;
    step();
    chk_out("cb_rst", {60'd0, if4.y0}, if4.y0_valid, {60'd0, if4.y1}, if4.y1_valid,
            route(64'hC, 1'b1, 1'b1));
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w = 64'($urandom_range(0, 15));
      v = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      if4.d = w[3:0]; if4.d_valid = v; if4.sel = s;
      #1;
      chk_out($sformatf("cb_rnd%0d", i), {60'd0, if4.y0}, if4.y0_valid,
              {60'd0, if4.y1}, if4.y1_valid, route(w, v, s));
    end

    // back-to-back throughput (WIDTH=16) against per-channel expected queues
    step();
    seen = 0;
    for (int k = 0; k < 32; k++) begin
      w = 64'($urandom_range(0, 65535));
      s = 1'($urandom_range(0, 1));
      if16.d = w[15:0]; if16.d_valid = 1'b1; if16.sel = s;
      if (s) exp_q1.push_back(w[15:0]);
      else   exp_q0.push_back(w[15:0]);
      step();
      chk($sformatf("tp%0d_one_valid", k), {62'd0, if16.y1_valid, if16.y0_valid},
          s ? 64'd2 : 64'd1);
      if (if16.y0_valid === 1'b1) begin
        chk($sformatf("tp%0d_q0_has", k), 64'(exp_q0.size() != 0), 64'd1);
        if (exp_q0.size() != 0) chk($sformatf("tp%0d_y0", k), {48'd0, if16.y0}, {48'd0, exp_q0.pop_front()});
        chk($sformatf("tp%0d_y1_idle", k), {47'd0, if16.y1_valid, if16.y1}, 64'd0);
        seen++;
      end else if (if16.y1_valid === 1'b1) begin
        chk($sformatf("tp%0d_q1_has", k), 64'(exp_q1.size() != 0), 64'd1);
        if (exp_q1.size() != 0) chk($sformatf("tp%0d_y1", k), {48'd0, if16.y1}, {48'd0, exp_q1.pop_front()});
        chk($sformatf("tp%0d_y0_idle", k), {47'd0, if16.y0_valid, if16.y0}, 64'd0);
        seen++;
      end
    end
    chk("tp_seen", 64'(seen), 64'd32);
    chk("tp_q_empty", 64'(exp_q0.size() + exp_q1.size()), 64'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
